booth_mac_acc: RTL



---
 rtl/booth_mac_acc.sv | 109 ++++++++++
 1 files changed

// File: rtl/booth_mac_acc.sv
// Registered signed multiply-accumulate stage fed by the Booth multiplier's product.
// Build option: define BOOTH_MAC_ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module booth_mac_acc #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] prod,
    input  logic                     in_last,
    input  logic                     clr,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]         count,
    output logic                     ovf,
    output logic                     out_valid,
    input  logic                     out_ready
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state, state_nxt;
    logic                    accept, clear_acc;
    logic signed [ACC_W-1:0] acc_p1, prod_ext, sum, acc_nxt;
    logic [CNT_W-1:0]        cnt_p1;
    logic                    ovf_p1, add_ovf;

    function automatic logic add_overflows(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state != DONE) && !clr;
        out_valid = (state == DONE);
        accept    = in_valid && in_ready;
        clear_acc = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if (clr) begin
                    state_nxt = IDLE;
                    clear_acc = 1'b1;
                end else if (accept) begin
                    state_nxt = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    clear_acc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign prod_ext = ACC_W'(prod);
    assign sum      = acc_p1 + prod_ext;
    assign add_ovf  = add_overflows(acc_p1[ACC_W-1], prod_ext[ACC_W-1], sum[ACC_W-1]);

`ifdef BOOTH_MAC_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Overflow can only happen toward the addend's sign, so that picks the rail.
    function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W-1:0] raw,
                                                         input logic ovf_now,
                                                         input logic addend_neg);
        if (ovf_now) begin
            return addend_neg ? ACC_MIN : ACC_MAX;
        end
        return raw;
    endfunction

    assign acc_nxt = saturate(sum, add_ovf, prod_ext[ACC_W-1]);
`else
    assign acc_nxt = sum;
`endif

    // Stage p1: accumulator, term count and sticky overflow, updated the cycle after accept
    always_ff @(posedge clk) begin
        if (rst || clear_acc) begin
            acc_p1 <= '0;
            cnt_p1 <= '0;
            ovf_p1 <= 1'b0;
        end else if (accept) begin
            acc_p1 <= acc_nxt;
            cnt_p1 <= sat_inc(cnt_p1);
            ovf_p1 <= ovf_p1 | add_ovf;
        end
    end

    assign acc_out = acc_p1;
    assign count   = cnt_p1;
    assign ovf     = ovf_p1;
endmodule
